// File: rtl/bn_seq_ctrl_if.sv
// Bundle of the sequencer's handshake and datapath signals.
// master: the environment around the sequencer (producer, datapath, consumer).
// slave:  the sequencer itself.
interface bn_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 4,
  parameter int CHANNEL    = 1
);
  localparam int VEC_W   = DATA_WIDTH * SIZE;
  localparam int SLICE_W = VEC_W / CHANNEL;

  logic               in_valid;
  logic               in_ready;
  logic [0:VEC_W-1]   in_data;
  logic [0:SLICE_W-1] bn_x;
  logic               bn_x_valid;
  logic [0:SLICE_W-1] bn_out;
  logic               out_valid;
  logic               out_ready;
  logic [0:VEC_W-1]   out_data;
  logic               busy;
  logic [15:0]        vec_cnt;

  modport master (
    output in_valid, in_data, bn_out, out_ready,
    input  in_ready, bn_x, bn_x_valid, out_valid, out_data, busy, vec_cnt
  );

  modport slave (
    input  in_valid, in_data, bn_out, out_ready,
    output in_ready, bn_x, bn_x_valid, out_valid, out_data, busy, vec_cnt
  );
endinterface

// File: rtl/bn_seq_ctrl.sv
// Batch-norm sequencer: takes one activation vector, streams it to the
// fixed-latency datapath CHANNEL slices at a time, collects the returned
// slices back into one vector and hands it downstream. One vector in flight.
module bn_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 4,
  parameter int CHANNEL    = 1,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         reset,
  bn_seq_ctrl_if.slave bus
);
  localparam int VEC_W   = DATA_WIDTH * SIZE;
  localparam int SLICE_W = VEC_W / CHANNEL;
  localparam int CW      = $clog2(CHANNEL + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_OUT} state_e;

  state_e             state_q;
  // Slices still to be issued; slice 0 always sits at the low-index end,
  // so issue order needs no variable indexing.
  logic [0:VEC_W-1]   in_buf_q;
  // Returned slices shift in from the high-index end; after CHANNEL captures
  // slice 0 has arrived at the low-index end, matching the input layout.
  logic [0:VEC_W-1]   out_buf_q;
  logic [0:SLICE_W-1] bn_x_q;
  logic               bn_x_valid_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               busy_q;
  logic [CW-1:0]      issue_cnt_q;
  logic [CW-1:0]      ret_cnt_q;
  logic [LATENCY-1:0] vld_pipe_q;
  logic [15:0]        vec_cnt_q;

  logic ret_vld;
  logic ret_last;

  // A slice is due back from the datapath when the tracker tail is set.
  assign ret_vld  = vld_pipe_q[LATENCY-1] && ((state_q == ST_ISSUE) || (state_q == ST_WAIT));
  assign ret_last = ret_vld && (ret_cnt_q == CW'(CHANNEL - 1));

  assign bus.in_ready   = in_ready_q;
  assign bus.bn_x       = bn_x_q;
  assign bus.bn_x_valid = bn_x_valid_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_buf_q;
  assign bus.busy       = busy_q;
  assign bus.vec_cnt    = vec_cnt_q;

  // Sequencer FSM with registered outputs, latency tracker and return capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      in_buf_q     <= '0;
      out_buf_q    <= '0;
      bn_x_q       <= '0;
      bn_x_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      vld_pipe_q   <= '0;
      vec_cnt_q    <= '0;
    end else begin
      // Tracker mirrors the datapath pipeline: one bit per cycle of latency.
      vld_pipe_q <= (vld_pipe_q << 1) | LATENCY'(bn_x_valid_q);

      if (ret_vld) begin
        out_buf_q <= (out_buf_q << SLICE_W) | VEC_W'(bus.bn_out);
        ret_cnt_q <= ret_cnt_q + CW'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            // Slice 0 goes out straight from the input so issue starts next cycle.
            bn_x_q       <= bus.in_data[0:SLICE_W-1];
            bn_x_valid_q <= 1'b1;
            in_buf_q     <= bus.in_data << SLICE_W;
            issue_cnt_q  <= CW'(1);
            ret_cnt_q    <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue_cnt_q == CW'(CHANNEL)) begin
            bn_x_valid_q <= 1'b0;
            state_q      <= ST_WAIT;
          end else begin
            bn_x_q      <= in_buf_q[0:SLICE_W-1];
            in_buf_q    <= in_buf_q << SLICE_W;
            issue_cnt_q <= issue_cnt_q + CW'(1);
          end
        end
        ST_WAIT: begin
          // bn_x keeps the last issued slice; only the tracker advances.
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            vec_cnt_q   <= vec_cnt_q + 16'd1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Last slice home: moving to OUT overrides whatever the case chose.
      if (ret_last) begin
        bn_x_valid_q <= 1'b0;
        out_valid_q  <= 1'b1;
        state_q      <= ST_OUT;
      end
    end
  end
endmodule
